spi_sniffer_stream: RTL and testbench
=====================================

Name: spi_sniffer_stream

Overview:
- Parametrised, single-clock SPI bus sniffer and the next generation of the existing `mosi`/`miso` capture block.
- Oversamples `spi_sck`, `ss`, `mosi` and `miso` in the `fifo_clk` domain and supports all four SPI modes with a configurable word width.
- Selects the MOSI or MISO word per the header/write-flag rule and emits tagged entries (word, partial word, frame end) through an internal FIFO.
- Output goes to the UART framer, with `uart_busy` backpressure and overflow accounting.

Parameters:
- WORD_BITS, 8: bits per captured word (4..16).
- FIFO_DEPTH, 16: output FIFO entries (power of 2, ≥2).
- SYNC_STAGES, 2: synchroniser flops on each SPI input (≥2).
- HDR_WORDS, 2: leading words of each frame always taken from MOSI.

Ports:
- fifo_clk  in  1  system clock; must be ≥4× SPI clock frequency.
- reset  in  1  synchronous, active-high reset.
- spi_sck  in  1  SPI clock, asynchronous.
- ss  in  1  slave select, active low, asynchronous.
- mosi  in  1  asynchronous.
- miso  in  1  asynchronous.
- mode  in  2  {CPOL,CPHA}; sampled at frame start.
- uart_busy  in  1  consumer busy; blocks pops.
- data  out  WORD_BITS  entry payload.
- data_kind  out  2  00 word, 01 partial word, 10 frame end, 11 unused.
- data_dir  out  1  0 = payload from MOSI, 1 = payload from MISO.
- data_valid  out  1  one-cycle pulse per popped entry.
- overflow  out  1  sticky; set on any dropped entry.
- drop_cnt  out  8  dropped entries, saturating at 255.

Behaviour:
- Reset: data=0, data_kind=0, data_dir=0, data_valid=0, overflow=0, drop_cnt=0. FIFO is emptied, synchronisers cleared, frame_active=0.
- After reset, capture resumes only at the next synchronised `ss` falling edge, even if `ss` is already low.
- Synchronisation: each SPI input passes through SYNC_STAGES flops. Edges are detected on the synchronised values against one further registered copy.
- Sample edge: rising `spi_sck` for mode 0 and 3; falling for mode 1 and 2, i.e. CPOL^CPHA selects falling.
- Frame start (synced `ss` 1→0):
  - latch `mode`;
  - bit_cnt=0, word_cnt=0, frame_active=1;
  - `mode` changes mid-frame are ignored.
- Capture (sample edge while frame_active and synced `ss` low):
  - shift mosi and miso MSB-first into two WORD_BITS shift registers;
  - the first bit of the frame is latched as write_flag.
- Word complete (bit_cnt reaches WORD_BITS):
  - push kind=00;
  - payload/dir: MOSI (dir 0) if word_cnt<HDR_WORDS or write_flag=1, else MISO (dir 1);
  - bit_cnt=0; word_cnt increments, saturating at 2^WORD_BITS-1.
- Frame end (synced `ss` 0→1 while frame_active):
  - if bit_cnt≠0: push kind=01 with the partial bits right-aligned (same dir rule), followed on the next cycle by a kind=10 entry;
  - if bit_cnt=0: push kind=10 only, with data=word_cnt (complete words only) and dir=0;
  - frame_active=0.
- Simultaneous sample edge and `ss` rise: the edge is ignored; the frame is closed.
- Push to a full FIFO:
  - the entry is dropped, overflow=1, drop_cnt increments (saturating at 255);
  - fullness is judged before any same-cycle pop, so a push into a full FIFO is dropped even if a pop happens that cycle.
- Pop condition: FIFO non-empty && !uart_busy && !data_valid. This gives at most one pop every 2 cycles, so the consumer has a cycle to raise `uart_busy`.
- Pop timing: data, data_kind and data_dir update in the same registered cycle that data_valid pulses, and hold until the next pop.
- Latency: an entry pushed in cycle N into an empty FIFO produces data_valid in cycle N+1 if `uart_busy` is low.
- FIFO pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- `overflow` and `drop_cnt` clear only on reset.

Test Plan:
- Mode 0, WORD_BITS=8, frame MOSI 0x80,0x12,0x34 with MISO 0xFF,0xFF,0x56 → entries (00,MOSI,0x80), (00,MOSI,0x12), (00,MOSI,0x34), (10,0,0x03). Write flag is 1, so all words come from MOSI.
- Mode 3, MOSI 0x05,0x20,0x00 with MISO 0x00,0x00,0xA7 → third entry is (00,dir 1,0xA7); then (10,0,0x03).
- Mode 1, 8 bits plus 3 bits 101b, then `ss` rise → (00,…), (01,…,0x05), (10,0,0x01).
- `uart_busy` held high with 20 words pushed and FIFO_DEPTH=16 → 16 retained; overflow=1; drop_cnt=5 (4 words plus the frame-end entry). On release, 16 pulses are spaced ≥2 cycles apart and `data` holds between them.
- Reset asserted mid-frame with `ss` still low → no entries until `ss` rises and falls again; the next frame captures correctly with the newly sampled `mode`.
- `mode` toggled mid-frame → the captured words are unaffected.

Source files
------------

// File: rtl/spi_sniffer_stream.sv
// SPI bus sniffer: oversamples the SPI pins in the fifo_clk domain, rebuilds
// MOSI/MISO words for any SPI mode, picks the relevant direction per word and
// streams tagged entries (word / partial word / frame end) to the UART framer.
module spi_sniffer_stream #(
  parameter int WORD_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int HDR_WORDS   = 2
) (
  input  logic                 fifo_clk,
  input  logic                 reset,
  input  logic                 spi_sck,
  input  logic                 ss,
  input  logic                 mosi,
  input  logic                 miso,
  input  logic [1:0]           mode,
  input  logic                 uart_busy,
  output logic [WORD_BITS-1:0] data,
  output logic [1:0]           data_kind,
  output logic                 data_dir,
  output logic                 data_valid,
  output logic                 overflow,
  output logic [7:0]           drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WORD_BITS + 1);
  localparam int EW = WORD_BITS + 3;
  localparam logic [1:0] KIND_WORD = 2'b00;
  localparam logic [1:0] KIND_PART = 2'b01;
  localparam logic [1:0] KIND_END  = 2'b10;
  localparam logic [WORD_BITS-1:0] HDR_LIM  = WORD_BITS'(HDR_WORDS);
  localparam logic [CW-1:0]        LAST_BIT = CW'(WORD_BITS - 1);
  localparam logic [AW:0]          FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // synchroniser chain, bit order {sck, ss, mosi, miso}
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  s;
  logic                        sck_d, ss_d;

  // frame capture state
  logic [1:0]           mode_q;
  logic                 frame_active, write_flag, end_pend;
  logic [CW-1:0]        bit_cnt;
  logic [WORD_BITS-1:0] word_cnt, sh_mosi, sh_miso, nxt_mosi, nxt_miso;

  // FIFO
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic          ss_fall, ss_rise, sck_rise, sck_fall, samp_edge;
  logic          capture, closing, word_done, use_mosi;
  logic          push, push_ok, drop, pop;
  logic [EW-1:0] push_ent;

  assign s = sync_q[SYNC_STAGES-1];

  // bring the asynchronous SPI pins into fifo_clk and keep one more copy for edges
  always_ff @(posedge fifo_clk) begin
    if (reset) begin
      sync_q <= '0;
      sck_d  <= 1'b0;
      ss_d   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {spi_sck, ss, mosi, miso}};
      sck_d  <= s[3];
      ss_d   <= s[2];
    end
  end

  // Cleared ss history means a pin already low after reset never looks like
  // a falling edge, so capture waits for a fresh frame.
  always_comb begin
    ss_fall   = ss_d & ~s[2];
    ss_rise   = ~ss_d & s[2];
    sck_rise  = ~sck_d & s[3];
    sck_fall  = sck_d & ~s[3];
    samp_edge = (mode_q[1] ^ mode_q[0]) ? sck_fall : sck_rise;
    closing   = frame_active & ss_rise;
    capture   = frame_active & ~s[2] & samp_edge;
    word_done = (bit_cnt == LAST_BIT);
    nxt_mosi  = {sh_mosi[WORD_BITS-2:0], s[1]};
    nxt_miso  = {sh_miso[WORD_BITS-2:0], s[0]};
    use_mosi  = (word_cnt < HDR_LIM) | write_flag;
  end

  // frame tracking and MSB-first shift; shifters are cleared per word so a
  // partial word is already right-aligned
  always_ff @(posedge fifo_clk) begin
    if (reset) begin
      mode_q       <= 2'b00;
      frame_active <= 1'b0;
      write_flag   <= 1'b0;
      end_pend     <= 1'b0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      sh_mosi      <= '0;
      sh_miso      <= '0;
    end else begin
      end_pend <= 1'b0;
      if (ss_fall) begin
        mode_q       <= mode;
        frame_active <= 1'b1;
        bit_cnt      <= '0;
        word_cnt     <= '0;
        sh_mosi      <= '0;
        sh_miso      <= '0;
      end else if (closing) begin
        frame_active <= 1'b0;
        end_pend     <= (bit_cnt != '0);
      end else if (capture) begin
        if (bit_cnt == '0 && word_cnt == '0) write_flag <= s[1];
        if (word_done) begin
          bit_cnt <= '0;
          sh_mosi <= '0;
          sh_miso <= '0;
          if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          sh_mosi <= nxt_mosi;
          sh_miso <= nxt_miso;
        end
      end
    end
  end

  // entry builder: frame-end marker trailing a partial word wins the slot
  always_comb begin
    push     = 1'b0;
    push_ent = '0;
    if (end_pend) begin
      push     = 1'b1;
      push_ent = {KIND_END, 1'b0, word_cnt};
    end else if (closing) begin
      push = 1'b1;
      if (bit_cnt != '0)
        push_ent = {KIND_PART, ~use_mosi, use_mosi ? sh_mosi : sh_miso};
      else
        push_ent = {KIND_END, 1'b0, word_cnt};
    end else if (capture && word_done) begin
      push     = 1'b1;
      push_ent = {KIND_WORD, ~use_mosi, use_mosi ? nxt_mosi : nxt_miso};
    end
  end

  // fullness is judged on the registered count, before any same-cycle pop
  always_comb begin
    push_ok = push & (count != FULL_CNT);
    drop    = push & (count == FULL_CNT);
    pop     = (count != '0) & ~uart_busy & ~data_valid;
  end

  // FIFO storage, no reset needed on the array
  always_ff @(posedge fifo_clk) begin
    if (push_ok) mem[wr_ptr] <= push_ent;
  end

  // pointers, occupancy, output register and overflow accounting
  always_ff @(posedge fifo_clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data       <= '0;
      data_kind  <= 2'b00;
      data_dir   <= 1'b0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      data_valid <= pop;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr                      <= rd_ptr + 1'b1;
        {data_kind, data_dir, data} <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_sniffer_stream.sv
// Scoreboard bench for spi_sniffer_stream: SPI frames are driven in all modes,
// expected entries are queued at drive time and checked as the DUT pops them.
module tb_spi_sniffer_stream;

  localparam int HP = 40;  // SPI half period, 8 fifo_clk cycles per SPI clock

  logic       fifo_clk = 1'b0;
  logic       reset, spi_sck, ss, mosi, miso, uart_busy;
  logic [1:0] mode;
  logic [7:0] data;
  logic [1:0] data_kind;
  logic       data_dir, data_valid, overflow;
  logic [7:0] drop_cnt;

  typedef struct packed {
    logic [1:0] kind;
    logic       dir;
    logic [7:0] dat;
  } ent_t;

  ent_t       sb[$];
  logic [7:0] mo_w [32];
  logic [7:0] mi_w [32];
  int         checks = 0;
  int         errors = 0;
  logic       hold_chk = 1'b0;
  logic [7:0] last_data = 8'd0;

  spi_sniffer_stream dut (
    .fifo_clk  (fifo_clk),
    .reset     (reset),
    .spi_sck   (spi_sck),
    .ss        (ss),
    .mosi      (mosi),
    .miso      (miso),
    .mode      (mode),
    .uart_busy (uart_busy),
    .data      (data),
    .data_kind (data_kind),
    .data_dir  (data_dir),
    .data_valid(data_valid),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 fifo_clk = ~fifo_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // pop side: every pulse must match the head of the scoreboard, be isolated,
  // and leave data stable on the following cycle
  always @(negedge fifo_clk) begin
    if (reset) begin
      hold_chk <= 1'b0;
    end else begin
      if (hold_chk) begin
        chk("gap", {31'd0, data_valid}, 32'd0);
        chk("hold", {24'd0, data}, {24'd0, last_data});
      end
      hold_chk <= data_valid;
      if (data_valid) begin
        last_data <= data;
        if (sb.size() == 0) begin
          chk("unexpected_entry", {31'd0, data_valid}, 32'd0);
        end else begin
          chk("kind", {30'd0, data_kind}, {30'd0, sb[0].kind});
          chk("dir", {31'd0, data_dir}, {31'd0, sb[0].dir});
          chk("data", {24'd0, data}, {24'd0, sb[0].dat});
          sb.delete(0);
        end
      end
    end
  end

  // queue the expected entries, then drive one SPI frame from mo_w/mi_w
  task automatic spi_frame(input logic [1:0] fmode, input int nbits, input int keep,
                           input logic toggle_mode);
    int   nfull, p, pushed;
    logic wf, d;
    ent_t e;
    nfull  = nbits / 8;
    p      = nbits % 8;
    pushed = 0;
    wf     = mo_w[0][7];
    for (int i = 0; i < nfull; i++) begin
      d = !(i < 2 || wf);
      e = '{kind: 2'b00, dir: d, dat: d ? mi_w[i] : mo_w[i]};
      if (pushed < keep) sb.push_back(e);
      pushed++;
    end
    if (p != 0) begin
      d = !(nfull < 2 || wf);
      e = '{kind: 2'b01, dir: d, dat: (d ? mi_w[nfull] : mo_w[nfull]) >> (8 - p)};
      if (pushed < keep) sb.push_back(e);
      pushed++;
    end
    e = '{kind: 2'b10, dir: 1'b0, dat: 8'(nfull)};
    if (pushed < keep) sb.push_back(e);

    mode    = fmode;
    spi_sck = fmode[1];
    repeat (8) @(posedge fifo_clk);
    ss = 1'b0;
    #(HP);
    for (int b = 0; b < nbits; b++) begin
      if (toggle_mode && b == 8) mode = ~fmode;
      if (!fmode[0]) begin
        mosi = mo_w[b/8][7 - b%8];
        miso = mi_w[b/8][7 - b%8];
        #(HP) spi_sck = ~spi_sck;
        #(HP) spi_sck = ~spi_sck;
      end else begin
        spi_sck = ~spi_sck;
        mosi = mo_w[b/8][7 - b%8];
        miso = mi_w[b/8][7 - b%8];
        #(HP) spi_sck = ~spi_sck;
        #(HP);
      end
    end
    #(HP);
    ss = 1'b1;
    repeat (10) @(posedge fifo_clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge fifo_clk);
    repeat (6) @(posedge fifo_clk);
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    @(negedge fifo_clk);
    chk({tag, "_data"}, {24'd0, data}, 32'd0);
    chk({tag, "_kind"}, {30'd0, data_kind}, 32'd0);
    chk({tag, "_dir"}, {31'd0, data_dir}, 32'd0);
    chk({tag, "_valid"}, {31'd0, data_valid}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_drops"}, {24'd0, drop_cnt}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; ss = 1'b1; spi_sck = 1'b0; mosi = 1'b0; miso = 1'b0;
    mode = 2'b00; uart_busy = 1'b0;
    repeat (4) @(posedge fifo_clk);
    chk_reset_state("rst");
    @(posedge fifo_clk);
    reset = 1'b0;
    repeat (10) @(posedge fifo_clk);

    // mode 0, write flag set: every word from MOSI
    mo_w[0] = 8'h80; mo_w[1] = 8'h12; mo_w[2] = 8'h34;
    mi_w[0] = 8'hFF; mi_w[1] = 8'hFF; mi_w[2] = 8'h56;
    spi_frame(2'b00, 24, 99, 1'b0);
    wait_drain();

    // mode 3, read frame: third word from MISO
    mo_w[0] = 8'h05; mo_w[1] = 8'h20; mo_w[2] = 8'h00;
    mi_w[0] = 8'h00; mi_w[1] = 8'h00; mi_w[2] = 8'hA7;
    spi_frame(2'b11, 24, 99, 1'b0);
    wait_drain();

    // mode 1, one word plus a 3-bit partial 101b
    mo_w[0] = 8'h3C; mo_w[1] = 8'hA0;
    mi_w[0] = 8'hC3; mi_w[1] = 8'h5F;
    spi_frame(2'b01, 11, 99, 1'b0);
    wait_drain();

    // mode 2, read frame past the header
    mo_w[0] = 8'h44; mo_w[1] = 8'h01; mo_w[2] = 8'h02; mo_w[3] = 8'h03;
    mi_w[0] = 8'h90; mi_w[1] = 8'h91; mi_w[2] = 8'hE2; mi_w[3] = 8'hE3;
    spi_frame(2'b10, 32, 99, 1'b0);
    wait_drain();

    // mode port toggled mid-frame must not disturb capture
    mo_w[0] = 8'h11; mo_w[1] = 8'h22; mo_w[2] = 8'h33;
    mi_w[0] = 8'hAA; mi_w[1] = 8'hBB; mi_w[2] = 8'hCC;
    spi_frame(2'b00, 24, 99, 1'b1);
    wait_drain();

    // consumer busy: 20 words + frame end into a 16-deep FIFO
    for (int i = 0; i < 20; i++) begin
      mo_w[i] = 8'(8'h81 + i);
      mi_w[i] = 8'(8'h40 + i);
    end
    uart_busy = 1'b1;
    spi_frame(2'b00, 160, 16, 1'b0);
    @(negedge fifo_clk);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_drops", {24'd0, drop_cnt}, 32'd5);
    chk("ovf_retained", sb.size(), 32'd16);
    uart_busy = 1'b0;
    wait_drain();
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // reset mid-frame with ss held low: nothing until a fresh ss fall
    mode = 2'b00; spi_sck = 1'b0;
    repeat (4) @(posedge fifo_clk);
    ss = 1'b0;
    #(HP);
    for (int b = 0; b < 4; b++) begin
      mosi = b[0];
      #(HP) spi_sck = 1'b1;
      #(HP) spi_sck = 1'b0;
    end
    @(posedge fifo_clk);
    reset = 1'b1;
    repeat (3) @(posedge fifo_clk);
    reset = 1'b0;
    chk_reset_state("midrst");
    for (int b = 0; b < 12; b++) begin
      mosi = b[1];
      miso = b[0];
      #(HP) spi_sck = 1'b1;
      #(HP) spi_sck = 1'b0;
    end
    #(HP);
    ss = 1'b1;
    repeat (20) @(posedge fifo_clk);
    chk("midrst_quiet", sb.size(), 32'd0);
    mo_w[0] = 8'h9A; mo_w[1] = 8'h5B; mo_w[2] = 8'h6C;
    mi_w[0] = 8'h01; mi_w[1] = 8'h02; mi_w[2] = 8'h03;
    spi_frame(2'b10, 24, 99, 1'b0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
